fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side master for the synchronous FIFO.
- Drives the FIFO read enable and captures read data, which arrives one cycle after the read enable.
- Presents the words downstream on a valid/ready stream through a 2-entry skid buffer, sustaining 1 word/cycle under continuous m_ready.
- Sits between the FIFO read port and any stream consumer; also provides a flush and a handshake counter.

Parameters:
DATA_W, 8, width of FIFO data word and stream data
CNT_W, 16, width of accepted-word counter

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
i_fifo_empty  input  1  FIFO empty flag
i_fifo_rddata  input  DATA_W  FIFO read data, valid the cycle after o_fifo_rden
o_fifo_rden  output  1  FIFO read enable (combinational)
o_m_valid  output  1  stream data valid
o_m_data  output  DATA_W  stream data (head of skid buffer)
i_m_ready  input  1  downstream ready
i_flush  input  1  discard buffered and in-flight words
o_busy  output  1  occ != 0 or in-flight read pending
o_pop_cnt  output  CNT_W  number of completed stream handshakes, wraps

Behaviour:
- Reset (rstn low, async):
  - occ = 0, inflight = 0, buffer contents = 0.
  - o_m_valid = 0, o_m_data = 0, o_busy = 0, o_pop_cnt = 0.
  - o_fifo_rden = 0 while rstn is low.
- State: occ (0..2 words held), inflight (1 bit = read issued last cycle), 2-entry buffer with head/tail pointers.
- Handshake: pop = o_m_valid && i_m_ready. o_m_valid = (occ != 0). o_m_data = buffer[head].
  - Once o_m_valid is high, o_m_data holds stable until pop.
- Read issue: o_fifo_rden = !i_fifo_empty && !i_flush && (occ + inflight - pop) <= 1.
  - Combinational path i_m_ready -> o_fifo_rden is intentional.
  - Never asserts while i_fifo_empty = 1.
- Capture: if inflight = 1, i_fifo_rddata is written to buffer[tail] at the clock edge; tail toggles, occ increments.
  - Next-state inflight = o_fifo_rden.
- Simultaneous capture and pop: occ unchanged, head and tail both advance.
- Latency: rden in cycle N -> data on i_fifo_rddata in N+1 -> o_m_valid = 1 in N+2 (if the buffer was empty).
- Throughput: with i_m_ready held high and FIFO non-empty, one handshake per cycle after the 2-cycle fill.
- Backpressure: with i_m_ready low, the buffer fills to occ = 2 and rden stops.
  - No overflow is possible: occ + inflight <= 2 at every edge.
- Flush (i_flush = 1 at an edge):
  - occ and pointers cleared; inflight cleared.
  - Data arriving from a read issued in the flush cycle cannot exist, because rden is forced 0 during flush.
  - Data arriving from a read issued the cycle before flush is discarded.
  - A pop coinciding with flush still counts in o_pop_cnt.
  - o_m_valid = 0 the cycle after the flush.
- o_pop_cnt: +1 per pop; wraps 2^CNT_W-1 -> 0. Not cleared by flush.
- Reset mid-operation: all state is cleared immediately. A read already issued to the FIFO is lost; the FIFO is reset by the same rstn.
- Words are delivered in FIFO order, with no duplication or loss except by flush or reset.

Test Plan:
- Reset: rstn = 0 with FIFO non-empty -> o_fifo_rden = 0, o_m_valid = 0, o_pop_cnt = 0, o_busy = 0; release -> rden = 1 in the first cycle.
- Single word: FIFO holds 0xA5, i_m_ready = 1 -> rden 1 cycle, o_m_valid = 1 with o_m_data = 0xA5 two cycles later, o_pop_cnt = 1, o_busy = 0 afterwards.
- Streaming: FIFO holds 0x01..0x08, i_m_ready = 1 -> 8 consecutive handshakes in cycles 2..9, data in order, o_pop_cnt = 8.
- Backpressure: FIFO holds 0x10..0x14, i_m_ready = 0 for 10 cycles -> exactly 2 reads issued, occ = 2, o_m_data = 0x10 stable; then i_m_ready = 1 -> 0x10..0x14 in order at 1/cycle.
- Flush: stream 0x20..0x27, assert i_flush for 1 cycle after 3 pops -> o_m_valid = 0 next cycle; later words resume from the FIFO with no stale 0x23/0x24 from the buffer; o_pop_cnt = 3 before resume.
- Counter wrap: CNT_W = 4, 17 pops -> o_pop_cnt = 1; mid-stream reset -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side master for a synchronous FIFO.
// Issues FIFO reads, captures the data that returns one cycle later into a
// 2-entry skid buffer, and presents the head word on a valid/ready stream.
// The read enable looks ahead at the current handshake, so a continuously
// ready consumer sees one word per cycle once the buffer has filled.
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    output logic              o_fifo_rden,
    output logic              o_m_valid,
    output logic [DATA_W-1:0] o_m_data,
    input  logic              i_m_ready,
    input  logic              i_flush,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_pop_cnt
);

    // Words held in the buffer (0..2) and whether a read returns this cycle.
    // occ_r + inflight_r never exceeds 2, so the sum always fits in 2 bits.
    logic [1:0]        occ_r;
    logic              inflight_r;
    logic              head_r;
    logic              tail_r;
    logic [DATA_W-1:0] buf_r [2];
    logic [CNT_W-1:0]  pop_cnt_r;

    logic              pop_s;
    logic [1:0]        need_s;
    logic              rden_s;

    // Handshake detection and read-issue decision for this cycle.
    always_comb begin
        pop_s  = 1'b0;
        need_s = 2'd0;
        rden_s = 1'b0;
        if (occ_r != 2'd0) begin
            pop_s = i_m_ready;
        end else begin
            pop_s = 1'b0;
        end
        // Slots committed after this edge: held + returning - leaving.
        // A pop implies occ_r >= 1, so the subtraction cannot underflow.
        need_s = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
        if (rstn && !i_fifo_empty && !i_flush && (need_s <= 2'd1)) begin
            rden_s = 1'b1;
        end else begin
            rden_s = 1'b0;
        end
    end

    // Occupancy, pointers and in-flight tracking; flush drops everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            head_r     <= 1'b0;
            tail_r     <= 1'b0;
        end else if (i_flush) begin
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            head_r     <= 1'b0;
            tail_r     <= 1'b0;
        end else begin
            inflight_r <= rden_s;
            if (inflight_r) begin
                tail_r <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            case ({inflight_r, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Capture returning read data into the tail slot; discarded on flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_r[0] <= '0;
            buf_r[1] <= '0;
        end else if (!i_flush && inflight_r) begin
            buf_r[tail_r] <= i_fifo_rddata;
        end
    end

    // Completed-handshake counter; wraps and survives flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pop_cnt_r <= '0;
        end else if (pop_s) begin
            pop_cnt_r <= pop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_fifo_rden = rden_s;
    assign o_m_valid   = (occ_r != 2'd0);
    assign o_m_data    = buf_r[head_r];
    assign o_busy      = (occ_r != 2'd0) || inflight_r;
    assign o_pop_cnt   = pop_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a behavioural FIFO feeds the DUT, the driver
// pushes hand-computed expected stream words into a scoreboard, and a
// monitor compares every stream handshake against it.
module tb_fifo_rd_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rstn;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rddata;
    logic              fifo_rden;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              flush;
    logic              busy;
    logic [CNT_W-1:0]  pop_cnt;

    // Behavioural FIFO storage: driver owns wr_ptr, FIFO process owns rd_ptr.
    logic [DATA_W-1:0] fifo_mem [0:63];
    int                wr_ptr = 0;
    int                rd_ptr = 0;
    logic              rden_q = 1'b0;

    // Scoreboard: driver owns exp_wr, monitor owns exp_rd.
    logic [DATA_W-1:0] exp_mem [0:63];
    int                exp_wr = 0;
    int                exp_rd = 0;
    logic              sb_en  = 1'b1;

    int                n_checks = 0;
    int                n_fail   = 0;

    fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_rddata (fifo_rddata),
        .o_fifo_rden   (fifo_rden),
        .o_m_valid     (m_valid),
        .o_m_data      (m_data),
        .i_m_ready     (m_ready),
        .i_flush       (flush),
        .o_busy        (busy),
        .o_pop_cnt     (pop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Sample the read enable mid-cycle, away from the edge.
    always @(negedge clk) rden_q <= fifo_rden;

    // FIFO read port: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (rden_q) begin
            fifo_rddata <= fifo_mem[rd_ptr[5:0]];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DATA_W-1:0] first, input int n);
        logic [DATA_W-1:0] v;
        v = first;
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[5:0]] = v;
            v = v + 8'd1;
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] v);
        exp_mem[exp_wr[5:0]] = v;
        exp_wr = exp_wr + 1;
    endtask

    // Monitor: compare every stream handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_en && m_valid && m_ready) begin
                if (exp_rd == exp_wr) begin
                    n_checks = n_checks + 1;
                    n_fail   = n_fail + 1;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data);
                end else begin
                    check("stream_data", 32'(m_data), 32'(exp_mem[exp_rd[5:0]]));
                    exp_rd = exp_rd + 1;
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        rstn    = 1'b0;
        m_ready = 1'b1;
        flush   = 1'b0;

        // Reset with FIFO non-empty.
        repeat (2) tick();
        load(8'hA5, 1);
        push_exp(8'hA5);
        tick();
        check("rst_rden",  32'(fifo_rden), 32'd0);
        check("rst_valid", 32'(m_valid),   32'd0);
        check("rst_data",  32'(m_data),    32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_cnt",   32'(pop_cnt),   32'd0);
        rstn = 1'b1;
        #1;
        check("rel_rden",  32'(fifo_rden), 32'd1);

        // Single word: valid two cycles after the read.
        tick();
        check("single_c1_valid", 32'(m_valid), 32'd0);
        check("single_c1_busy",  32'(busy),    32'd1);
        tick();
        check("single_c2_valid", 32'(m_valid), 32'd1);
        check("single_c2_data",  32'(m_data),  32'hA5);
        tick();
        check("single_cnt",   32'(pop_cnt), 32'd1);
        check("single_busy",  32'(busy),    32'd0);
        check("single_valid", 32'(m_valid), 32'd0);

        // Streaming 0x01..0x08 at one word per cycle.
        load(8'h01, 8);
        for (int i = 0; i < 8; i++) push_exp(8'h01 + 8'(i));
        repeat (9) tick();
        check("stream_cnt_c9",  32'(pop_cnt), 32'd8);
        tick();
        check("stream_cnt_c10", 32'(pop_cnt), 32'd9);
        check("stream_busy",    32'(busy),    32'd0);
        check("stream_drained", 32'(exp_rd),  32'(exp_wr));

        // Backpressure: only two reads, head word held stable.
        m_ready = 1'b0;
        load(8'h10, 5);
        for (int i = 0; i < 5; i++) push_exp(8'h10 + 8'(i));
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i >= 3) check("bp_hold_data", 32'(m_data), 32'h10);
        end
        check("bp_reads", 32'(rd_ptr),    32'd11);
        check("bp_valid", 32'(m_valid),   32'd1);
        check("bp_rden",  32'(fifo_rden), 32'd0);
        check("bp_busy",  32'(busy),      32'd1);
        m_ready = 1'b1;
        repeat (5) tick();
        check("bp_cnt",     32'(pop_cnt), 32'd14);
        check("bp_busy_end", 32'(busy),   32'd0);
        check("bp_drained", 32'(exp_rd),  32'(exp_wr));

        // Flush after three pops: 0x23 (buffered) and 0x24 (in flight) dropped.
        load(8'h20, 8);
        push_exp(8'h20);
        push_exp(8'h21);
        push_exp(8'h22);
        push_exp(8'h25);
        push_exp(8'h26);
        push_exp(8'h27);
        repeat (5) tick();
        check("flush_cnt_wrap", 32'(pop_cnt), 32'd1);
        m_ready = 1'b0;
        flush   = 1'b1;
        #1;
        check("flush_rden", 32'(fifo_rden), 32'd0);
        tick();
        check("flush_valid", 32'(m_valid), 32'd0);
        check("flush_busy",  32'(busy),    32'd0);
        check("flush_cnt",   32'(pop_cnt), 32'd1);
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (5) tick();
        check("resume_cnt",     32'(pop_cnt), 32'd4);
        check("resume_reads",   32'(rd_ptr),  32'd22);
        check("resume_busy",    32'(busy),    32'd0);
        check("resume_drained", 32'(exp_rd),  32'(exp_wr));

        // Mid-stream asynchronous reset.
        sb_en = 1'b0;
        load(8'h30, 8);
        repeat (4) tick();
        check("pre_rst_cnt",   32'(pop_cnt), 32'd6);
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(m_valid),   32'd0);
        check("mid_rst_data",  32'(m_data),    32'd0);
        check("mid_rst_cnt",   32'(pop_cnt),   32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_rden",  32'(fifo_rden), 32'd0);
        tick();
        rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
